imem_loader: RTL and testbench

- Instruction-memory responder for the fetch stage, plus a byte-stream program loader.
- The loader accepts a valid/ready byte stream, assembles little-endian 32-bit words and writes them sequentially into instruction memory from word 0.
- While loading, it holds the pipeline via cpu_hold. This signal drives the fetch stall and core reset.
- Fetch reads instructions combinationally by byte PC through a separate read port.

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 178 +++++++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Bus bundle for imem_loader: load control, byte stream and fetch read port.
// The slave modport is the loader itself; the master modport is the driving side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              cpu_hold;
  logic              load_done;
  logic [ADDR_W:0]   words_loaded;
  logic [31:0]       fetch_pc;
  logic [31:0]       fetch_instr;
  logic              fetch_err;

  modport master (
    output load_start, load_len, rx_valid, rx_data, fetch_pc,
    input  rx_ready, cpu_hold, load_done, words_loaded, fetch_instr, fetch_err
  );

  modport slave (
    input  load_start, load_len, rx_valid, rx_data, fetch_pc,
    output rx_ready, cpu_hold, load_done, words_loaded, fetch_instr, fetch_err
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with a combinational fetch port and a byte-stream loader
// that assembles little-endian words and holds the CPU while loading.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] LEN_ZERO  = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LEN_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              state_r;
  state_t              state_next_s;

  logic [31:0]         mem_r [0:DEPTH-1];

  logic [1:0]          byte_cnt_r;
  logic [23:0]         word_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [ADDR_W:0]     words_loaded_r;
  logic [ADDR_W:0]     target_r;

  logic                rx_ready_r;
  logic                cpu_hold_r;
  logic                load_done_r;

  logic                rx_ready_next_s;
  logic                cpu_hold_next_s;
  logic                load_done_next_s;

  logic                start_s;
  logic                start_empty_s;
  logic [ADDR_W:0]     target_s;
  logic                byte_fire_s;
  logic                word_done_s;
  logic                last_word_s;

  // Handshake and word-completion qualifiers shared by FSM and datapath.
  always_comb begin
    start_s       = (state_r == ST_IDLE) && bus.load_start;
    start_empty_s = start_s && (bus.load_len == LEN_ZERO);
    target_s      = (bus.load_len > LEN_DEPTH) ? LEN_DEPTH : bus.load_len;
    byte_fire_s   = (state_r == ST_LOAD) && bus.rx_valid && rx_ready_r;
    word_done_s   = byte_fire_s && (byte_cnt_r == 2'd3);
    last_word_s   = word_done_s && ((words_loaded_r + LEN_ONE) == target_r);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start_s && !start_empty_s) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (last_word_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    rx_ready_next_s  = 1'b0;
    cpu_hold_next_s  = 1'b0;
    load_done_next_s = 1'b0;
    case (state_next_s)
      ST_LOAD: begin
        rx_ready_next_s = 1'b1;
        cpu_hold_next_s = 1'b1;
      end
      ST_IDLE: begin
        rx_ready_next_s = 1'b0;
        cpu_hold_next_s = 1'b0;
      end
      default: begin
        rx_ready_next_s = 1'b0;
        cpu_hold_next_s = 1'b0;
      end
    endcase
    if (start_empty_s || last_word_s) begin
      load_done_next_s = 1'b1;
    end else begin
      load_done_next_s = 1'b0;
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_r  <= 1'b0;
      cpu_hold_r  <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      rx_ready_r  <= rx_ready_next_s;
      cpu_hold_r  <= cpu_hold_next_s;
      load_done_r <= load_done_next_s;
    end
  end

  // Byte assembly, write address and progress counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_r     <= 2'd0;
      word_r         <= 24'd0;
      wr_addr_r      <= '0;
      words_loaded_r <= LEN_ZERO;
      target_r       <= LEN_ZERO;
    end else if (start_s) begin
      byte_cnt_r     <= 2'd0;
      word_r         <= 24'd0;
      wr_addr_r      <= '0;
      words_loaded_r <= LEN_ZERO;
      target_r       <= target_s;
    end else if (byte_fire_s) begin
      if (byte_cnt_r == 2'd3) begin
        byte_cnt_r     <= 2'd0;
        word_r         <= 24'd0;
        wr_addr_r      <= wr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        words_loaded_r <= words_loaded_r + LEN_ONE;
      end else begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        case (byte_cnt_r)
          2'd0:    word_r[7:0]   <= bus.rx_data;
          2'd1:    word_r[15:8]  <= bus.rx_data;
          2'd2:    word_r[23:16] <= bus.rx_data;
          default: word_r        <= word_r;
        endcase
      end
    end
  end

  // Memory write port; contents survive reset, the 4th byte goes straight into bits [31:24].
  always_ff @(posedge clk) begin
    if (word_done_s) begin
      mem_r[wr_addr_r] <= {bus.rx_data, word_r};
    end
  end

  assign bus.rx_ready     = rx_ready_r;
  assign bus.cpu_hold     = cpu_hold_r;
  assign bus.load_done    = load_done_r;
  assign bus.words_loaded = words_loaded_r;

  // Upper PC bits only flag an error; indexing always uses the in-range word bits.
  assign bus.fetch_instr = mem_r[bus.fetch_pc[ADDR_W+1:2]];
  assign bus.fetch_err   = (bus.fetch_pc[1:0] != 2'b00) ||
                           (bus.fetch_pc[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams against a
// word-array reference model of the loaded program.
module tb_imem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clk;
  logic rst;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [31:0] mem_model [0:DEPTH-1];
  bit          known     [0:DEPTH-1];
  logic [7:0]  tx_bytes  [$];

  // Reference: word w of a load is bytes 4w..4w+3, little-endian.
  task automatic apply_model(input int words);
    for (int w = 0; w < words; w++) begin
      mem_model[w] = {tx_bytes[4*w+3], tx_bytes[4*w+2], tx_bytes[4*w+1], tx_bytes[4*w]};
      known[w] = 1'b1;
    end
  endtask

  task automatic random_bytes(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
  endtask

  // Drives one load; returns observed statistics, stops at load_done or budget.
  task automatic drive_load(input int len, input bit gaps, input int budget,
                            output int accepted, output int done_cnt,
                            output int hold_bad, output int ready_bad);
    int  cyc;
    bit  fire;
    accepted = 0; done_cnt = 0; hold_bad = 0; ready_bad = 0; cyc = 0;
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_len   = (ADDR_W+1)'(len);
    @(negedge clk);
    bus.load_start = 1'b0;
    while (cyc < budget) begin
      if (bus.load_done === 1'b1) begin
        done_cnt++;
        break;
      end
      if (bus.cpu_hold !== 1'b1) hold_bad++;
      if (bus.rx_ready !== 1'b1) ready_bad++;
      if ((!gaps || (cyc % 2 == 0)) && (accepted < tx_bytes.size())) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = tx_bytes[accepted];
      end else begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
      end
      fire = bus.rx_valid && (bus.rx_ready === 1'b1);
      @(negedge clk);
      if (fire) accepted++;
      cyc++;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp += 4;
    if (bus.rx_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_rx_ready got %b exp 0", bus.rx_ready); end
    if (bus.cpu_hold !== 1'b0)  begin n_bad++; $display("FAIL reset_cpu_hold got %b exp 0", bus.cpu_hold); end
    if (bus.load_done !== 1'b0) begin n_bad++; $display("FAIL reset_load_done got %b exp 0", bus.load_done); end
    if (bus.words_loaded !== 9'd0) begin n_bad++; $display("FAIL reset_words got %0d exp 0", bus.words_loaded); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (bus.rx_ready !== 1'b0) begin n_bad++; $display("FAIL idle_rx_ready got %b exp 0", bus.rx_ready); end
    if (bus.cpu_hold !== 1'b0) begin n_bad++; $display("FAIL idle_cpu_hold got %b exp 0", bus.cpu_hold); end
  endtask

  task automatic test_basic_load;
    int acc, dn, hb, rb;
    tx_bytes = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    drive_load(2, 1'b0, 100, acc, dn, hb, rb);
    apply_model(2);
    n_cmp += 6;
    if (dn !== 1)  begin n_bad++; $display("FAIL basic_done got %0d exp 1", dn); end
    if (acc !== 8) begin n_bad++; $display("FAIL basic_accepted got %0d exp 8", acc); end
    if (hb !== 0)  begin n_bad++; $display("FAIL basic_hold_low got %0d exp 0", hb); end
    if (bus.cpu_hold !== 1'b0) begin n_bad++; $display("FAIL basic_hold_at_done got %b exp 0", bus.cpu_hold); end
    if (bus.words_loaded !== 9'd2) begin n_bad++; $display("FAIL basic_words got %0d exp 2", bus.words_loaded); end
    if (rb !== 0)  begin n_bad++; $display("FAIL basic_ready_low got %0d exp 0", rb); end
    @(negedge clk);
    n_cmp += 3;
    if (bus.load_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b exp 0", bus.load_done); end
    if (bus.rx_ready !== 1'b0)  begin n_bad++; $display("FAIL basic_ready_after got %b exp 0", bus.rx_ready); end
    if (bus.cpu_hold !== 1'b0)  begin n_bad++; $display("FAIL basic_hold_after got %b exp 0", bus.cpu_hold); end
    bus.fetch_pc = 32'h0; #1;
    n_cmp++;
    if (bus.fetch_instr !== 32'h00500013) begin n_bad++; $display("FAIL basic_mem0 got %h exp 00500013", bus.fetch_instr); end
    bus.fetch_pc = 32'h4; #1;
    n_cmp++;
    if (bus.fetch_instr !== 32'h00100093) begin n_bad++; $display("FAIL basic_mem1 got %h exp 00100093", bus.fetch_instr); end
  endtask

  task automatic test_gapped_load;
    int acc, dn, hb, rb;
    random_bytes(12);
    drive_load(3, 1'b1, 200, acc, dn, hb, rb);
    apply_model(3);
    n_cmp += 5;
    if (dn !== 1)   begin n_bad++; $display("FAIL gap_done got %0d exp 1", dn); end
    if (acc !== 12) begin n_bad++; $display("FAIL gap_accepted got %0d exp 12", acc); end
    if (rb !== 0)   begin n_bad++; $display("FAIL gap_ready_low got %0d exp 0", rb); end
    if (hb !== 0)   begin n_bad++; $display("FAIL gap_hold_low got %0d exp 0", hb); end
    if (bus.words_loaded !== 9'd3) begin n_bad++; $display("FAIL gap_words got %0d exp 3", bus.words_loaded); end
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      bus.fetch_pc = 32'(w * 4); #1;
      n_cmp++;
      if (bus.fetch_instr !== mem_model[w]) begin n_bad++; $display("FAIL gap_mem%0d got %h exp %h", w, bus.fetch_instr, mem_model[w]); end
    end
  endtask

  task automatic test_zero_len;
    int acc, dn, hb, rb;
    random_bytes(8);
    drive_load(0, 1'b0, 20, acc, dn, hb, rb);
    n_cmp += 4;
    if (dn !== 1)  begin n_bad++; $display("FAIL zero_done got %0d exp 1", dn); end
    if (acc !== 0) begin n_bad++; $display("FAIL zero_accepted got %0d exp 0", acc); end
    if (bus.cpu_hold !== 1'b0) begin n_bad++; $display("FAIL zero_hold got %b exp 0", bus.cpu_hold); end
    if (bus.words_loaded !== 9'd0) begin n_bad++; $display("FAIL zero_words got %0d exp 0", bus.words_loaded); end
    @(negedge clk);
    n_cmp += 2;
    if (bus.load_done !== 1'b0) begin n_bad++; $display("FAIL zero_done_width got %b exp 0", bus.load_done); end
    if (bus.cpu_hold !== 1'b0)  begin n_bad++; $display("FAIL zero_hold_after got %b exp 0", bus.cpu_hold); end
    for (int w = 0; w < 3; w++) begin
      bus.fetch_pc = 32'(w * 4); #1;
      n_cmp++;
      if (bus.fetch_instr !== mem_model[w]) begin n_bad++; $display("FAIL zero_mem%0d got %h exp %h", w, bus.fetch_instr, mem_model[w]); end
    end
  endtask

  task automatic test_clamp;
    int acc, dn, hb, rb;
    random_bytes(1030);
    drive_load(300, 1'b0, 1500, acc, dn, hb, rb);
    apply_model(DEPTH);
    n_cmp += 4;
    if (dn !== 1)     begin n_bad++; $display("FAIL clamp_done got %0d exp 1", dn); end
    if (acc !== 1024) begin n_bad++; $display("FAIL clamp_accepted got %0d exp 1024", acc); end
    if (hb !== 0)     begin n_bad++; $display("FAIL clamp_hold_low got %0d exp 0", hb); end
    if (bus.words_loaded !== 9'd256) begin n_bad++; $display("FAIL clamp_words got %0d exp 256", bus.words_loaded); end
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if (bus.rx_ready !== 1'b0) begin n_bad++; $display("FAIL clamp_ready_after got %b exp 0", bus.rx_ready); end
    end
    bus.rx_valid = 1'b0;
    n_cmp++;
    if (bus.words_loaded !== 9'd256) begin n_bad++; $display("FAIL clamp_words_after got %0d exp 256", bus.words_loaded); end
    for (int w = 0; w < DEPTH; w++) begin
      @(negedge clk);
      bus.fetch_pc = 32'(w * 4); #1;
      n_cmp++;
      if (bus.fetch_instr !== mem_model[w]) begin n_bad++; $display("FAIL clamp_mem%0d got %h exp %h", w, bus.fetch_instr, mem_model[w]); end
    end
  endtask

  task automatic test_reset_abort;
    int done_seen;
    random_bytes(8);
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_len   = 9'd2;
    @(negedge clk);
    bus.load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = tx_bytes[i];
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    apply_model(1);
    rst = 1'b1;
    #1;
    n_cmp += 4;
    if (bus.rx_ready !== 1'b0)  begin n_bad++; $display("FAIL abort_rx_ready got %b exp 0", bus.rx_ready); end
    if (bus.cpu_hold !== 1'b0)  begin n_bad++; $display("FAIL abort_cpu_hold got %b exp 0", bus.cpu_hold); end
    if (bus.load_done !== 1'b0) begin n_bad++; $display("FAIL abort_load_done got %b exp 0", bus.load_done); end
    if (bus.words_loaded !== 9'd0) begin n_bad++; $display("FAIL abort_words got %0d exp 0", bus.words_loaded); end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.load_done !== 1'b0) done_seen++;
    end
    n_cmp += 2;
    if (done_seen !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d exp 0", done_seen); end
    if (bus.cpu_hold !== 1'b0) begin n_bad++; $display("FAIL abort_hold_after got %b exp 0", bus.cpu_hold); end
    for (int w = 0; w < 2; w++) begin
      bus.fetch_pc = 32'(w * 4); #1;
      n_cmp++;
      if (bus.fetch_instr !== mem_model[w]) begin n_bad++; $display("FAIL abort_mem%0d got %h exp %h", w, bus.fetch_instr, mem_model[w]); end
    end
  endtask

  task automatic test_fetch;
    logic [31:0] pc;
    logic        exp_err;
    @(negedge clk);
    bus.fetch_pc = 32'h4; #1;
    n_cmp += 2;
    if (bus.fetch_instr !== mem_model[1]) begin n_bad++; $display("FAIL fetch_pc4_instr got %h exp %h", bus.fetch_instr, mem_model[1]); end
    if (bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL fetch_pc4_err got %b exp 0", bus.fetch_err); end
    bus.fetch_pc = 32'h6; #1;
    n_cmp++;
    if (bus.fetch_err !== 1'b1) begin n_bad++; $display("FAIL fetch_pc6_err got %b exp 1", bus.fetch_err); end
    bus.fetch_pc = 32'h400; #1;
    n_cmp += 2;
    if (bus.fetch_err !== 1'b1) begin n_bad++; $display("FAIL fetch_pc400_err got %b exp 1", bus.fetch_err); end
    if (bus.fetch_instr !== mem_model[0]) begin n_bad++; $display("FAIL fetch_pc400_instr got %h exp %h", bus.fetch_instr, mem_model[0]); end
    for (int i = 0; i < 40; i++) begin
      pc = $urandom;
      if (i % 3 == 0) pc[31:10] = 22'd0;
      if (i % 2 == 0) pc[1:0] = 2'd0;
      exp_err = ((pc % 4) != 0) || (pc >= 32'(DEPTH * 4));
      bus.fetch_pc = pc; #1;
      n_cmp += 2;
      if (bus.fetch_err !== exp_err) begin n_bad++; $display("FAIL fetch_rand_err pc %h got %b exp %b", pc, bus.fetch_err, exp_err); end
      if (bus.fetch_instr !== mem_model[(pc / 4) % DEPTH]) begin
        n_bad++; $display("FAIL fetch_rand_instr pc %h got %h exp %h", pc, bus.fetch_instr, mem_model[(pc / 4) % DEPTH]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int w = 0; w < DEPTH; w++) begin
      mem_model[w] = 32'h0;
      known[w] = 1'b0;
    end
    rst            = 1'b1;
    bus.load_start = 1'b0;
    bus.load_len   = 9'd0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'd0;
    bus.fetch_pc   = 32'd0;
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_zero_len();
    test_clamp();
    test_reset_abort();
    test_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
